rr_arb_5: RTL

RR_ARB_5 -- requirements
Module: rr_arb_5

---
 rtl/noc_pkg.sv | 6 +
 rtl/rr_pick5.sv | 25 ++
 rtl/rr_arb_5.sv | 64 ++++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared widths, input count and select-code type for the round-robin arbiter
package noc_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int NUM_IN = 5;
  typedef logic [2:0] sel_t;
endpackage

// File: rtl/rr_pick5.sv
// rr_pick5: rotating-priority scan; picks the first set req bit starting at ptr, modulo 5 (ports: req, ptr -> grant one-hot, idx)
module rr_pick5
  import noc_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  sel_t              ptr,
  output logic [NUM_IN-1:0] grant,
  output sel_t              idx
);
  sel_t j;
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    // scan from the farthest offset down so the nearest requester wins the last write
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      j = sel_t'((32'(ptr) + k) % NUM_IN);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/rr_arb_5.sv
// rr_arb_5: 5-input round-robin arbiter with a one-word output register
// ports: clk, reset (async high), in_valid/in_ready/in_data0..4 upstream, out_valid/out_ready/out_data/out_sel downstream;
// optional grant_cnt (5x16 saturating grant counters) when RR_ARB_5_GRANT_CNT_EN is defined
module rr_arb_5 #(
  parameter int WIDTH = noc_pkg::WIDTH_DEF,
  parameter int NUM_IN = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] in_valid,
  input  logic [WIDTH-1:0]  in_data0,
  input  logic [WIDTH-1:0]  in_data1,
  input  logic [WIDTH-1:0]  in_data2,
  input  logic [WIDTH-1:0]  in_data3,
  input  logic [WIDTH-1:0]  in_data4,
  output logic [NUM_IN-1:0] in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output noc_pkg::sel_t     out_sel,
  input  logic              out_ready
`ifdef RR_ARB_5_GRANT_CNT_EN
  ,
  output logic [NUM_IN-1:0][15:0] grant_cnt
`endif
);
  noc_pkg::sel_t ptr, idx;
  logic [NUM_IN-1:0] grant;
  logic [WIDTH-1:0] pick_data;
  logic load, take;
  rr_pick5 u_pick (.req(in_valid), .ptr(ptr), .grant(grant), .idx(idx));
  // reset gates in_ready combinationally so nothing is accepted while it is held
  always_comb begin
    load = !out_valid | out_ready;
    take = load & |in_valid & !reset;
    in_ready = {NUM_IN{load & !reset}} & grant;
    pick_data = idx == 3'd0 ? in_data0 :
                idx == 3'd1 ? in_data1 :
                idx == 3'd2 ? in_data2 :
                idx == 3'd3 ? in_data3 : in_data4;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= take;
      if (take) begin
        out_data <= pick_data;
        out_sel <= idx;
        ptr <= idx == 3'd4 ? 3'd0 : idx + 3'd1;
      end
    end
  end
`ifdef RR_ARB_5_GRANT_CNT_EN
  for (genvar i = 0; i < NUM_IN; i++) begin : g_cnt
    always_ff @(posedge clk or posedge reset) begin
      if (reset) grant_cnt[i] <= '0;
      else if (in_ready[i] && grant_cnt[i] != 16'hFFFF) grant_cnt[i] <= grant_cnt[i] + 16'd1;
    end
  end
`endif
endmodule
